// File: rtl/exmem_arbiter.sv
// Two-requester arbiter for a shared BRAM with a fixed access latency.
// A Wishbone classic slave and an engine port compete for single-word accesses.
// Ties go to whichever side was not granted last.
// The owner holds the BRAM for DELAYS cycles, then sees a one-cycle acknowledge.
module exmem_arbiter #(
  parameter int DELAYS = 10,
  parameter int ADDR_W = 12
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              wbs_stb_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              eng_req_i,
  input  logic              eng_we_i,
  input  logic [ADDR_W-1:0] eng_addr_i,
  input  logic [31:0]       eng_wdat_i,
  output logic              eng_gnt_o,
  output logic              eng_ack_o,
  output logic [31:0]       eng_rdat_o,
  output logic              bram_en_o,
  output logic [3:0]        bram_we_o,
  output logic [31:0]       bram_addr_o,
  output logic [31:0]       bram_di_o,
  input  logic [31:0]       bram_do_i
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST_CNT = 4'(DELAYS);

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        last_eng;
  logic        owner_eng;
  logic        we_l;
  logic [3:0]  mask_l;
  logic [31:0] addr_l;
  logic [31:0] wdat_l;

  logic        wb_req;
  logic        any_req;
  logic        grant_eng;
  logic        at_last;
  logic        wb_abort;
  logic        finish;
  logic        unused_adr;

  // Only the top address byte and bits [ADDR_W+1:2] carry meaning; the rest is reduced here.
  assign unused_adr = ^wbs_adr_i;

  // Byte lanes to strobe: reads never write, engine writes are always full words.
  function automatic logic [3:0] byte_mask(input logic is_eng, input logic is_we,
                                           input logic [3:0] sel);
    if (!is_we)      return 4'b0000;
    else if (is_eng) return 4'b1111;
    else             return sel;
  endfunction

  assign wb_req    = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:24] == 8'h38);
  assign any_req   = wb_req || eng_req_i;
  // Engine wins when it is alone, or on a tie when the Wishbone side was served last.
  assign grant_eng = eng_req_i && (!wb_req || !last_eng);
  assign at_last   = (cnt == LAST_CNT);
  assign wb_abort  = (state == S_WAIT) && !owner_eng && !wbs_cyc_i;
  assign finish    = (state == S_WAIT) && at_last && !wb_abort;
  assign eng_gnt_o = owner_eng && (state != S_IDLE);

  // Next state and BRAM drive; the port is quiet outside WAIT and never strobed on an abort.
  always_comb begin
    state_nxt   = state;
    bram_en_o   = 1'b0;
    bram_we_o   = 4'b0000;
    bram_addr_o = 32'h0;
    bram_di_o   = 32'h0;
    case (state)
      S_IDLE: if (any_req) state_nxt = S_WAIT;
      S_WAIT: begin
        bram_en_o   = 1'b1;
        bram_addr_o = addr_l;
        bram_di_o   = wdat_l;
        if (wb_abort) begin
          state_nxt = S_IDLE;
        end else if (at_last) begin
          state_nxt = S_DONE;
          bram_we_o = mask_l;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, latency counter, fairness pointer and the registered acknowledge/data outputs.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state      <= S_IDLE;
      cnt        <= 4'd0;
      last_eng   <= 1'b1;
      wbs_ack_o  <= 1'b0;
      eng_ack_o  <= 1'b0;
      wbs_dat_o  <= 32'h0;
      eng_rdat_o <= 32'h0;
    end else begin
      state     <= state_nxt;
      wbs_ack_o <= 1'b0;
      eng_ack_o <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt <= any_req ? 4'd1 : 4'd0;
          if (any_req) last_eng <= grant_eng;
        end
        S_WAIT: begin
          cnt <= (wb_abort || at_last) ? 4'd0 : cnt + 4'd1;
          if (finish) begin
            if (owner_eng) begin
              eng_ack_o  <= 1'b1;
              eng_rdat_o <= we_l ? 32'h0 : bram_do_i;
            end else begin
              wbs_ack_o  <= 1'b1;
              wbs_dat_o  <= we_l ? 32'h0 : bram_do_i;
            end
          end
        end
        default: cnt <= 4'd0;
      endcase
    end
  end

  // Capture the winning request; these registers are only looked at while an access is in flight.
  always_ff @(posedge wb_clk_i) begin
    if (state == S_IDLE && any_req) begin
      owner_eng <= grant_eng;
      we_l      <= grant_eng ? eng_we_i : wbs_we_i;
      mask_l    <= byte_mask(grant_eng, grant_eng ? eng_we_i : wbs_we_i, wbs_sel_i);
      addr_l    <= grant_eng ? 32'({eng_addr_i, 2'b00})
                             : 32'({wbs_adr_i[ADDR_W+1:2], 2'b00});
      wdat_l    <= grant_eng ? eng_wdat_i : wbs_dat_i;
    end
  end

endmodule

// File: tb/tb_exmem_arbiter.sv
// Directed bench for exmem_arbiter with a 16-word behavioural BRAM.
module tb_exmem_arbiter;

  localparam int DELAYS = 10;
  localparam int ADDR_W = 12;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_ni = 1'b0;
  logic              wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]        wbs_sel_i = 4'h0;
  logic [31:0]       wbs_adr_i = 32'h0, wbs_dat_i = 32'h0;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              eng_req_i = 1'b0, eng_we_i = 1'b0;
  logic [ADDR_W-1:0] eng_addr_i = '0;
  logic [31:0]       eng_wdat_i = 32'h0;
  logic              eng_gnt_o, eng_ack_o;
  logic [31:0]       eng_rdat_o;
  logic              bram_en_o;
  logic [3:0]        bram_we_o;
  logic [31:0]       bram_addr_o, bram_di_o, bram_do_i;

  exmem_arbiter #(.DELAYS(DELAYS), .ADDR_W(ADDR_W)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_ni(wb_rst_ni),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .eng_req_i(eng_req_i), .eng_we_i(eng_we_i), .eng_addr_i(eng_addr_i),
    .eng_wdat_i(eng_wdat_i), .eng_gnt_o(eng_gnt_o), .eng_ack_o(eng_ack_o),
    .eng_rdat_o(eng_rdat_o), .bram_en_o(bram_en_o), .bram_we_o(bram_we_o),
    .bram_addr_o(bram_addr_o), .bram_di_o(bram_di_o), .bram_do_i(bram_do_i)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Behavioural BRAM: combinational read, byte-lane write on the clock edge.
  logic [31:0] mem [0:15];
  logic        load_mem = 1'b1;
  assign bram_do_i = mem[bram_addr_o[5:2]];

  always @(posedge wb_clk_i) begin
    if (load_mem) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hAAAA_AAAA;
      mem[4] <= 32'hDEAD_BEEF;
      mem[5] <= 32'h0123_4567;
      mem[6] <= 32'h89AB_CDEF;
    end else if (bram_en_o) begin
      for (int b = 0; b < 4; b++)
        if (bram_we_o[b]) mem[bram_addr_o[5:2]][8*b +: 8] <= bram_di_o[8*b +: 8];
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  // One Wishbone transfer, observed for ncyc cycles after the first request edge.
  task automatic wb_access(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                           input logic [31:0] dat, input int ncyc,
                           output int ack_cyc, output int ack_n, output int en_n,
                           output int we_n, output int we_cyc, output logic [3:0] we_val,
                           output logic [31:0] di_val, output logic [31:0] addr1);
    ack_cyc = 0; ack_n = 0; en_n = 0; we_n = 0; we_cyc = 0;
    we_val = 4'h0; di_val = 32'h0; addr1 = 32'h0;
    wbs_adr_i = adr; wbs_we_i = we; wbs_sel_i = sel; wbs_dat_i = dat;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    for (int c = 1; c <= ncyc; c++) begin
      tick;
      if (c == 1) addr1 = bram_addr_o;
      if (bram_en_o) en_n++;
      if (bram_we_o != 4'h0) begin
        we_n++; we_cyc = c; we_val = bram_we_o; di_val = bram_di_o;
      end
      if (wbs_ack_o) begin
        ack_n++;
        if (ack_cyc == 0) ack_cyc = c;
        wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  int          a_cyc, a_n, e_n, w_n, w_cyc;
  logic [3:0]  w_val;
  logic [31:0] d_val, addr1;
  int          wb_ack1, wb_ack2, e_ack, wb_n, e_cnt, we_early;
  logic [31:0] d1, d2, ed;
  logic        gnt5, gnt6, gnt7, gnt13, en6;

  initial begin
    repeat (3) tick;
    load_mem = 1'b0;

    // Reset state
    chk("rst_acks", 32'({wbs_ack_o, eng_ack_o, eng_gnt_o}), 32'h0);
    chk("rst_bram_ctl", 32'({bram_en_o, bram_we_o}), 32'h0);
    chk("rst_bram_addr", bram_addr_o, 32'h0);
    chk("rst_wb_dat", wbs_dat_o, 32'h0);
    wb_rst_ni = 1'b1;

    // Wishbone read of word 4
    wb_access(32'h3800_0010, 1'b0, 4'hF, 32'h0, 14, a_cyc, a_n, e_n, w_n, w_cyc, w_val, d_val, addr1);
    chk("rd_ack_cycle", 32'(a_cyc), 32'd11);
    chk("rd_ack_count", 32'(a_n), 32'd1);
    chk("rd_data", wbs_dat_o, 32'hDEAD_BEEF);
    chk("rd_bram_addr", addr1, 32'h0000_0010);
    chk("rd_no_write", 32'(w_n), 32'd0);
    chk("rd_en_cycles", 32'(e_n), 32'd10);

    // Wishbone partial write to word 8
    wb_access(32'h3800_0020, 1'b1, 4'b0011, 32'h1234_5678, 14, a_cyc, a_n, e_n, w_n, w_cyc, w_val, d_val, addr1);
    chk("wr_we_count", 32'(w_n), 32'd1);
    chk("wr_we_cycle", 32'(w_cyc), 32'd10);
    chk("wr_we_mask", 32'(w_val), 32'h3);
    chk("wr_di", d_val, 32'h1234_5678);
    chk("wr_ack_cycle", 32'(a_cyc), 32'd11);
    chk("wr_ack_count", 32'(a_n), 32'd1);
    chk("wr_dat_zero", wbs_dat_o, 32'h0);
    chk("wr_mem", mem[8], 32'hAAAA_5678);

    // Ties after reset: WB first, engine next, then WB's back-to-back request
    wb_rst_ni = 1'b0; tick; wb_rst_ni = 1'b1;
    wb_ack1 = 0; wb_ack2 = 0; e_ack = 0; wb_n = 0;
    d1 = 32'h0; d2 = 32'h0; ed = 32'h0; gnt5 = 1'b1; gnt13 = 1'b0;
    wbs_adr_i = 32'h3800_0010; wbs_we_i = 1'b0; wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    eng_req_i = 1'b1; eng_we_i = 1'b0; eng_addr_i = 12'd5;
    for (int c = 1; c <= 40; c++) begin
      tick;
      if (c == 5)  gnt5  = eng_gnt_o;
      if (c == 13) gnt13 = eng_gnt_o;
      if (wbs_ack_o) begin
        wb_n++;
        if (wb_n == 1) begin
          wb_ack1 = c; d1 = wbs_dat_o; wbs_adr_i = 32'h3800_0018;
        end else begin
          wb_ack2 = c; d2 = wbs_dat_o; wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0;
        end
      end
      if (eng_ack_o) begin
        e_ack = c; ed = eng_rdat_o; eng_req_i = 1'b0;
      end
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; eng_req_i = 1'b0;
    chk("tie_wb_ack", 32'(wb_ack1), 32'd11);
    chk("tie_eng_ack", 32'(e_ack), 32'd23);
    chk("tie2_wb_ack", 32'(wb_ack2), 32'd35);
    chk("tie_wb_count", 32'(wb_n), 32'd2);
    chk("tie_wb_data", d1, 32'hDEAD_BEEF);
    chk("tie_eng_data", ed, 32'h0123_4567);
    chk("tie2_wb_data", d2, 32'h89AB_CDEF);
    chk("tie_gnt_wb_phase", 32'(gnt5), 32'd0);
    chk("tie_gnt_eng_phase", 32'(gnt13), 32'd1);

    // Address outside the window is ignored
    wb_access(32'h3000_0000, 1'b0, 4'hF, 32'h0, 50, a_cyc, a_n, e_n, w_n, w_cyc, w_val, d_val, addr1);
    chk("oob_ack_count", 32'(a_n), 32'd0);
    chk("oob_en_cycles", 32'(e_n), 32'd0);

    // WB write aborted at cnt=5 while the engine waits
    wbs_adr_i = 32'h3800_0024; wbs_we_i = 1'b1; wbs_sel_i = 4'hF; wbs_dat_i = 32'h5555_5555;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    tick;
    eng_req_i = 1'b1; eng_we_i = 1'b1; eng_addr_i = 12'd7; eng_wdat_i = 32'h0BAD_F00D;
    we_early = 0; wb_n = 0; e_ack = 0; en6 = 1'b1; gnt6 = 1'b1; gnt7 = 1'b0;
    for (int c = 2; c <= 30; c++) begin
      tick;
      if (c <= 6 && bram_we_o != 4'h0) we_early++;
      if (wbs_ack_o) wb_n++;
      if (c == 5) begin wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; end
      if (c == 6) begin en6 = bram_en_o; gnt6 = eng_gnt_o; end
      if (c == 7) gnt7 = eng_gnt_o;
      if (eng_ack_o) begin e_ack = c; eng_req_i = 1'b0; end
    end
    eng_req_i = 1'b0; wbs_we_i = 1'b0;
    chk("abort_no_we", 32'(we_early), 32'd0);
    chk("abort_no_ack", 32'(wb_n), 32'd0);
    chk("abort_idle_en", 32'(en6), 32'd0);
    chk("abort_idle_gnt", 32'(gnt6), 32'd0);
    chk("abort_eng_gnt", 32'(gnt7), 32'd1);
    chk("abort_eng_ack", 32'(e_ack), 32'd17);
    chk("abort_mem_wb", mem[9], 32'hAAAA_AAAA);
    chk("abort_mem_eng", mem[7], 32'h0BAD_F00D);

    // Reset in the middle of an engine write, then a clean retry
    eng_req_i = 1'b1; eng_we_i = 1'b1; eng_addr_i = 12'd3; eng_wdat_i = 32'hCAFE_F00D;
    repeat (3) tick;
    wb_rst_ni = 1'b0;
    tick;
    chk("mid_rst_ctl", 32'({wbs_ack_o, eng_ack_o, eng_gnt_o, bram_en_o, bram_we_o}), 32'h0);
    chk("mid_rst_addr", bram_addr_o, 32'h0);
    chk("mid_rst_di", bram_di_o, 32'h0);
    chk("mid_rst_wb_dat", wbs_dat_o, 32'h0);
    chk("mid_rst_eng_dat", eng_rdat_o, 32'h0);
    chk("mid_rst_mem", mem[3], 32'hAAAA_AAAA);
    wb_rst_ni = 1'b1;
    e_cnt = 0; e_ack = 0;
    for (int c = 1; c <= 15; c++) begin
      tick;
      if (eng_ack_o) begin
        e_cnt++;
        if (e_ack == 0) e_ack = c;
        eng_req_i = 1'b0;
      end
    end
    eng_req_i = 1'b0;
    chk("retry_ack_cycle", 32'(e_ack), 32'd11);
    chk("retry_ack_count", 32'(e_cnt), 32'd1);
    chk("retry_mem", mem[3], 32'hCAFE_F00D);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/exmem_arbiter.md
EXMEM_ARBITER -- requirements
Module: exmem_arbiter

Interface
REQ-001 Parameter DELAYS, default 10: BRAM access latency in cycles, legal range 1..15.
REQ-002 Parameter ADDR_W, default 12: word-address width of the shared BRAM.
REQ-003 wb_clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-004 wb_rst_ni  in  1  reset, synchronous, active-low.
REQ-005 wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone classic slave strobe, cycle and write enable.
REQ-006 wbs_sel_i  in  4  Wishbone byte select.
REQ-007 wbs_adr_i, wbs_dat_i  in  32 each  Wishbone byte address and write data.
REQ-008 wbs_ack_o  out  1  Wishbone acknowledge, registered.
REQ-009 wbs_dat_o  out  32  Wishbone read data, registered.
REQ-010 eng_req_i  in  1  engine access request, held until eng_ack_o.
REQ-011 eng_we_i  in  1  engine write (full 32-bit word).
REQ-012 eng_addr_i  in  ADDR_W  engine word address.
REQ-013 eng_wdat_i  in  32  engine write data.
REQ-014 eng_gnt_o  out  1  engine owns BRAM (high from WAIT entry through DONE).
REQ-015 eng_ack_o  out  1  engine access complete, registered one-cycle pulse.
REQ-016 eng_rdat_o  out  32  engine read data, valid with eng_ack_o.
REQ-017 bram_en_o  out  1  BRAM enable.
REQ-018 bram_we_o  out  4  BRAM byte write enables.
REQ-019 bram_addr_o  out  32  BRAM byte address; bits [1:0] always 0.
REQ-020 bram_di_o  out  32  BRAM write data.
REQ-021 bram_do_i  in  32  BRAM read data.

Function
REQ-022 WB request valid when wbs_stb_i & wbs_cyc_i & wbs_adr_i[31:24]==8'h38; other addresses are ignored and never acked.
REQ-023 FSM states IDLE, WAIT, DONE; 4-bit latency counter cnt.
REQ-024 IDLE: with any valid request, grant per REQ-025, latch owner/we/byte mask/address/write data, set cnt=1, go WAIT; no request -> stay IDLE.
REQ-025 Arbitration: a single requester wins; on a tie the requester not granted last wins; last-granted pointer updates on every grant; after reset WB wins the first tie.
REQ-026 Address latch: WB -> {wbs_adr_i[ADDR_W+1:2],2'b00}; engine -> {eng_addr_i,2'b00}; zero-extended to 32 bits.
REQ-027 Byte mask: WB write -> wbs_sel_i; engine write -> 4'b1111; any read -> 4'b0000.
REQ-028 WAIT: bram_en_o=1 with latched address/data; cnt increments each cycle; bram_we_o = latched mask only in the cycle cnt==DELAYS, else 0.
REQ-029 WAIT exit at edge with cnt==DELAYS: go DONE; owner ack register <=1; owner data register <= bram_do_i on read, 0 on write.
REQ-030 DONE: one cycle, bram_en_o=0, ack high; next edge ack<=0, go IDLE; data register holds until next ack.
REQ-031 Latency: idle BRAM, request first sampled at edge 0 -> ack high in cycle DELAYS+1, exactly one cycle wide.
REQ-032 Non-owner requests are ignored during WAIT/DONE and remain pending; engine waits at most one full WB access and vice versa.
REQ-033 WB abort: wbs_cyc_i low during WAIT with WB owner -> next edge IDLE, no write strobe, no ack, pointer unchanged.
REQ-034 Engine cannot abort; eng_req_i falling before eng_ack_o is illegal (no defined behaviour required).
REQ-035 Outside WAIT all bram_* outputs are 0.

Reset
REQ-036 wb_rst_ni low at an edge: state IDLE, cnt=0, pointer=engine-last, all outputs 0, including mid-WAIT (in-flight access dropped, no write, no ack).

Verification
REQ-037 WB read 0x3800_0010, DELAYS=10, BRAM word 4 = 0xDEADBEEF -> wbs_ack_o high in cycle 11 only, wbs_dat_o=0xDEADBEEF, bram_addr_o=0x10.
REQ-038 WB write sel=4'b0011 data 0x12345678 -> bram_we_o=4'b0011 for exactly one cycle (cnt==10), wbs_ack_o one pulse, wbs_dat_o=0.
REQ-039 WB and engine request same cycle after reset -> WB served first, engine acked DELAYS+2 cycles after WB ack; repeat tie -> engine first.
REQ-040 WB address 0x3000_0000 -> no bram_en_o, no ack for 50 cycles.
REQ-041 Drop wbs_cyc_i at cnt=5 of a WB write -> bram_we_o never nonzero, no ack, IDLE next cycle, pending engine request granted next.
REQ-042 Assert wb_rst_ni low at cnt=3 of an engine write -> all outputs 0 next cycle, no write, engine re-request completes normally.
